// File: rtl/tower_draw_scheduler.sv
// Tower placement scheduler: validates requests, queues them and sequences the 20x20 sprite drawer.
// Optional draw timeout with sticky err is enabled by defining TOWER_SCHED_TIMEOUT_EN.
module tower_draw_scheduler #(
    parameter int GRID_W     = 8,
    parameter int GRID_H     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 511
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_gx,
    input  logic [3:0]               req_gy,
    output logic                     req_reject,
    input  logic                     clr,
    output logic [3:0]               drw_gx,
    output logic [3:0]               drw_gy,
    output logic                     drw_en,
    input  logic                     drw_done,
    output logic                     plot,
    output logic                     busy,
    output logic [GRID_W*GRID_H-1:0] occ_map,
    output logic [5:0]               tower_count,
    output logic                     err,
    output logic [1:0]               o_dbg_state
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDXW  = $clog2(CELLS);
    localparam int PW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_fifo_cnt;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic             r_clr_pend;
    logic             w_clr_apply;
    logic             w_hs;
    logic             w_in_range;
    logic             w_occ_hit;
    logic             w_accept;
    logic             w_reject;
    logic [IDXW-1:0]  w_idx;
    logic [CELLS-1:0] r_occ;
    logic [CELLS-1:0] w_occ_set;
    logic [5:0]       r_count;
    logic [3:0]       r_drw_gx;
    logic [3:0]       r_drw_gy;
    logic             r_plot;
    logic             r_reject;
    logic [1:0]       r_mask_cnt;
    logic             w_done_seen;
    logic             w_timeout;

    // Request handshake: a transfer happens on any cycle where req_valid && req_ready;
    // req_gx/req_gy are only meaningful while req_valid is high.
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_fifo_full  = (r_fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign req_ready    = !w_fifo_full && !r_clr_pend;
    assign w_hs         = req_valid && req_ready;

    // A clear seen mid-draw waits for GAP so the drawer is never cut off.
    assign w_clr_apply = (clr && (r_state != S_DRAW)) || (r_clr_pend && (r_state == S_GAP));

    assign w_in_range = ({1'b0, req_gx} < 5'(GRID_W)) && ({1'b0, req_gy} < 5'(GRID_H));
    assign w_idx      = IDXW'(req_gy) * IDXW'(GRID_W) + IDXW'(req_gx);
    assign w_occ_hit  = w_in_range && r_occ[w_idx];
    assign w_accept   = w_hs && !w_clr_apply && w_in_range && !w_occ_hit;
    assign w_reject   = w_hs && !w_clr_apply && !(w_in_range && !w_occ_hit);
    assign w_occ_set  = w_accept ? (CELLS'(1) << w_idx) : '0;
    assign w_push     = w_accept;
    assign w_pop      = (r_state == S_IDLE) && !w_fifo_empty && !w_clr_apply;

    // The drawer can leave done high from its previous sprite; ignore it for two DRAW cycles.
    assign w_done_seen = (r_state == S_DRAW) && drw_done && (r_mask_cnt == 2'd2);

    always_comb begin
        w_state_nxt = r_state;
        drw_en      = 1'b0;
        case (r_state)
            S_IDLE: if (w_pop) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = w_clr_apply ? S_IDLE : S_DRAW;
            S_DRAW: begin
                drw_en = resetn;
                if (w_done_seen || w_timeout) w_state_nxt = S_GAP;
            end
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {req_gx, req_gy};
    end

    always_ff @(posedge clk) begin
        if (!resetn || w_clr_apply) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_occ      <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (PW+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (PW+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            r_occ <= r_occ | w_occ_set;
            if (w_accept) r_count <= r_count + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_drw_gx   <= '0;
            r_drw_gy   <= '0;
            r_plot     <= 1'b0;
            r_reject   <= 1'b0;
            r_clr_pend <= 1'b0;
            r_mask_cnt <= '0;
        end else begin
            if (w_pop) {r_drw_gx, r_drw_gy} <= r_fifo[r_rd_ptr];
            // Plot trails drw_en by one cycle for the drawer RAM, and stops once DRAW is left.
            r_plot   <= (r_state == S_DRAW) && (w_state_nxt == S_DRAW);
            r_reject <= w_reject;
            if (w_clr_apply)                        r_clr_pend <= 1'b0;
            else if (clr && (r_state == S_DRAW))    r_clr_pend <= 1'b1;
            if (r_state != S_DRAW)                  r_mask_cnt <= '0;
            else if (r_mask_cnt != 2'd2)            r_mask_cnt <= r_mask_cnt + 2'd1;
        end
    end

`ifdef TOWER_SCHED_TIMEOUT_EN
    logic [8:0] r_to_cnt;
    logic       r_err;

    assign w_timeout = (r_state == S_DRAW) && (r_to_cnt == 9'(TIMEOUT - 1));
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_DRAW) ? r_to_cnt + 9'd1 : 9'd0;
            if (w_clr_apply)    r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign req_reject  = r_reject;
    assign drw_gx      = r_drw_gx;
    assign drw_gy      = r_drw_gy;
    assign plot        = r_plot;
    assign busy        = (r_state != S_IDLE) || !w_fifo_empty;
    assign occ_map     = r_occ;
    assign tower_count = r_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tower_draw_scheduler.sv
// Directed bench for tower_draw_scheduler: drawer model, draw scoreboard and placement model.
module tb_tower_draw_scheduler;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  req_gx = '0;
    logic [3:0]  req_gy = '0;
    logic        req_ready, req_reject, drw_en, drw_done, plot, busy, err;
    logic [3:0]  drw_gx, drw_gy;
    logic [47:0] occ_map;
    logic [5:0]  tower_count;
    logic [1:0]  dbg_state;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    logic [47:0] m_occ = '0;
    int          m_count = 0;

    int          draw_len = 10;
    bit          done_stuck = 1'b0;
    int          en_cnt = 0;
    bit          abort_ok = 1'b0;

    logic        prev_en = 1'b0;
    logic [1:0]  prev_state = ST_IDLE;
    int          en_len = 0;
    int          plot_cnt = 0;
    int          last_en_len = 0;
    int          last_plot_cnt = 0;
    int          draws = 0;

    tower_draw_scheduler dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_gx      (req_gx),
        .req_gy      (req_gy),
        .req_reject  (req_reject),
        .clr         (clr),
        .drw_gx      (drw_gx),
        .drw_gy      (drw_gy),
        .drw_en      (drw_en),
        .drw_done    (drw_done),
        .plot        (plot),
        .busy        (busy),
        .occ_map     (occ_map),
        .tower_count (tower_count),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // Clock and drawer model: done rises once the drawer has run draw_len enabled cycles.
    always #5 clk = ~clk;
    always @(posedge clk) en_cnt <= drw_en ? en_cnt + 1 : 0;
    assign drw_done = drw_en && !done_stuck && (en_cnt == draw_len);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_occ   = '0;
        m_count = 0;
        exp_q.delete();
    endtask

    task automatic send(input int gx, input int gy);
        int  waited = 0;
        bit  acc;
        req_valid = 1'b1;
        req_gx    = gx[3:0];
        req_gy    = gy[3:0];
        while (!req_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", waited < 2000, 1'b1);
        acc = (gx < 8) && (gy < 6) && !m_occ[gy*8 + gx];
        if (acc) begin
            m_occ[gy*8 + gx] = 1'b1;
            m_count++;
            exp_q.push_back({gx[3:0], gy[3:0]});
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("reject", req_reject, !acc);
    endtask

    task automatic wait_en(input int budget);
        int n = 0;
        while (!drw_en && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_en", n < budget, 1'b1);
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        int n = 0;
        while (dbg_state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", n < budget, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", busy, 1'b0);
    endtask

    // Draw scoreboard: each drw_en rise pops the expected cell; each fall checks GAP and plot length.
    always @(negedge clk) begin
        if (drw_en && !prev_en) begin
            chk("load_before_draw", prev_state, ST_LOAD);
            chk("plot_lags_en", plot, 1'b0);
            chk("draw_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) chk("draw_cell", {drw_gx, drw_gy}, exp_q.pop_front());
            en_len   = 1;
            plot_cnt = 0;
        end else if (drw_en) begin
            en_len++;
            if (plot) plot_cnt++;
        end
        if (!drw_en && prev_en) begin
            if (plot) plot_cnt++;
            if (!abort_ok) begin
                chk("gap_after_draw", dbg_state, ST_GAP);
                chk("plot_len", plot_cnt, en_len - 1);
            end
            last_en_len   = en_len;
            last_plot_cnt = plot_cnt;
            draws++;
        end
        prev_en    = drw_en;
        prev_state = dbg_state;
    end

    initial begin
        int         d0;
        logic [47:0] pre;

        repeat (3) @(negedge clk);
        chk("rst_occ", occ_map, 48'h0);
        chk("rst_count", tower_count, 6'd0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_en", drw_en, 1'b0);
        chk("rst_plot", plot, 1'b0);
        chk("rst_reject", req_reject, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_drw_xy", {drw_gx, drw_gy}, 8'h00);
        resetn = 1'b1;
        @(negedge clk);

        // Single placement with a 400-cycle sprite.
        draw_len = 400;
        send(2, 3);
        chk("occ_bit26", occ_map[26], 1'b1);
        chk("occ_map_1", occ_map, m_occ);
        chk("count_1", tower_count, 6'd1);
        wait_idle(1000);
        chk("plot_400", last_plot_cnt, 400);
        chk("en_401", last_en_len, 401);
        chk("draws_1", draws, 1);

        // Out-of-range requests after a clear.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        chk("clr_occ", occ_map, 48'h0);
        chk("clr_count", tower_count, 6'd0);
        draw_len = 10;
        send(8, 0);
        send(1, 6);
        chk("oor_occ", occ_map, m_occ);
        chk("oor_count", tower_count, 6'd0);

        // Request coinciding with an applied clear is silently dropped.
        req_valid = 1'b1;
        req_gx    = 4'd5;
        req_gy    = 4'd5;
        clr       = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        clr       = 1'b0;
        chk("clr_hs_reject", req_reject, 1'b0);
        chk("clr_hs_count", tower_count, 6'd0);
        chk("clr_hs_busy", busy, 1'b0);

        // Duplicate cell back-to-back.
        d0 = draws;
        send(4, 4);
        send(4, 4);
        wait_idle(200);
        chk("dup_draws", draws, d0 + 1);
        chk("dup_count", tower_count, 6'(m_count));

        // Five requests while a draw is running: FIFO fills at four.
        draw_len = 40;
        d0 = draws;
        send(5, 0);
        wait_en(20);
        send(0, 1);
        send(1, 1);
        send(2, 1);
        send(3, 1);
        chk("full_ready", req_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        send(4, 1);
        wait_idle(2000);
        chk("drain_draws", draws, d0 + 6);
        chk("drain_occ", occ_map, m_occ);
        chk("drain_count", tower_count, 6'(m_count));
        chk("drain_q", exp_q.size(), 0);

        // Clear during a draw is deferred to GAP.
        draw_len = 30;
        send(0, 0);
        send(1, 1);
        wait_en(20);
        pre = m_occ;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        chk("clr_pend_ready", req_ready, 1'b0);
        chk("clr_deferred", occ_map, pre);
        wait_state(ST_GAP, 100);
        @(negedge clk);
        chk("clr_gap_occ", occ_map, 48'h0);
        chk("clr_gap_count", tower_count, 6'd0);
        chk("clr_gap_busy", busy, 1'b0);
        chk("clr_gap_ready", req_ready, 1'b1);

        // Reset in the middle of a draw on the last cell.
        draw_len = 50;
        send(7, 5);
        chk("occ_bit47", occ_map[47], 1'b1);
        wait_en(20);
        repeat (3) @(negedge clk);
        abort_ok = 1'b1;
        resetn   = 1'b0;
        #1;
        chk("rst_en_drop", drw_en, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        model_clear();
        chk("mid_rst_state", dbg_state, ST_IDLE);
        chk("mid_rst_occ", occ_map, 48'h0);
        chk("mid_rst_count", tower_count, 6'd0);
        chk("mid_rst_plot", plot, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        abort_ok = 1'b0;

`ifdef TOWER_SCHED_TIMEOUT_EN
        // Drawer never finishes: timeout after 511 DRAW cycles.
        done_stuck = 1'b1;
        send(6, 2);
        wait_idle(800);
        chk("to_en_len", last_en_len, 511);
        chk("to_err", err, 1'b1);
        chk("to_occ_kept", occ_map, m_occ);
        done_stuck = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        chk("to_err_clr", err, 1'b0);
`else
        chk("err_tied", err, 1'b0);
`endif

        chk("final_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
